program_sequencer: RTL and testbench

- Multi-cycle FSM controller for the X/Y/Z + ULA calculator datapath.
- Replaces the free-running address counter and the purely combinational command decoder.
- Fetches commands from the clocked program memory, decodes them into ULA select and X/Y/Z register commands, and stalls on multi-cycle ULA operations (MUL/DIV) until the ULA status goes high.
- Provides a start/busy/done handshake, jumps and halt.

---
 rtl/program_sequencer.sv | 151 +++++++++++++++
 tb/tb_program_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/decode/wait FSM driving the X/Y/Z + ULA calculator datapath
module program_sequencer #(
  parameter int ADDR_WIDTH    = 4,
  parameter int CMD_WIDTH     = 4,
  parameter int ULA_SEL_WIDTH = 4,
  parameter int REG_CMD_WIDTH = 3,
  parameter int WAIT_LIMIT    = 16
) (
  input  logic                     clockSequencer,
  input  logic                     resetSequencer,
  input  logic                     startSequencer,
  input  logic [CMD_WIDTH-1:0]     comandSequencer,
  input  logic [ADDR_WIDTH-1:0]    jumpSequencer,
  input  logic                     statusSequencer,
  output logic [ADDR_WIDTH-1:0]    addressSequencer,
  output logic [ULA_SEL_WIDTH-1:0] tULASequencer,
  output logic [REG_CMD_WIDTH-1:0] tXSequencer,
  output logic [REG_CMD_WIDTH-1:0] tYSequencer,
  output logic [REG_CMD_WIDTH-1:0] tZSequencer,
  output logic                     busySequencer,
  output logic                     doneSequencer,
  output logic                     errorSequencer
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [CMD_WIDTH-1:0] OP_NOP = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] OP_LDX = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] OP_ADD = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] OP_SUB = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] OP_MUL = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] OP_DIV = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] OP_STZ = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] OP_CLR = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] OP_JMP = CMD_WIDTH'(8);
  localparam logic [CMD_WIDTH-1:0] OP_HLT = CMD_WIDTH'(15);

  localparam logic [ULA_SEL_WIDTH-1:0] ULA_ADD = ULA_SEL_WIDTH'(0);
  localparam logic [ULA_SEL_WIDTH-1:0] ULA_SUB = ULA_SEL_WIDTH'(1);
  localparam logic [ULA_SEL_WIDTH-1:0] ULA_MUL = ULA_SEL_WIDTH'(2);
  localparam logic [ULA_SEL_WIDTH-1:0] ULA_DIV = ULA_SEL_WIDTH'(3);

  localparam logic [REG_CMD_WIDTH-1:0] RC_HOLD  = REG_CMD_WIDTH'(0);
  localparam logic [REG_CMD_WIDTH-1:0] RC_LOAD  = REG_CMD_WIDTH'(1);
  localparam logic [REG_CMD_WIDTH-1:0] RC_CLEAR = REG_CMD_WIDTH'(2);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  logic [2:0]               state;
  logic [ADDR_WIDTH-1:0]    pc;
  logic [ULA_SEL_WIDTH-1:0] ula_op;
  logic [WCW-1:0]           wait_cnt;

  always_ff @(posedge clockSequencer) begin
    if (resetSequencer) begin
      state    <= S_IDLE;
      pc       <= '0;
      ula_op   <= ULA_ADD;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (startSequencer) begin
            state <= S_FETCH;
            pc    <= '0;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (comandSequencer)
            OP_NOP, OP_LDX, OP_ADD, OP_SUB, OP_STZ, OP_CLR: begin
              pc    <= pc + ADDR_WIDTH'(1);
              state <= S_FETCH;
            end
            OP_JMP: begin
              pc    <= jumpSequencer;
              state <= S_FETCH;
            end
            OP_MUL, OP_DIV: begin
              ula_op   <= (comandSequencer == OP_MUL) ? ULA_MUL : ULA_DIV;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
            OP_HLT:  state <= S_HALT;
            default: state <= S_ERROR;
          endcase
        end
        S_WAIT: begin
          if (statusSequencer) begin
            pc    <= pc + ADDR_WIDTH'(1);
            state <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
            if (wait_cnt == WCW'(WAIT_LIMIT - 1))
              state <= S_ERROR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only EXEC looks at the memory word; WAIT replays the latched multi-cycle op.
  always_comb begin
    tULASequencer = ULA_ADD;
    tXSequencer   = RC_HOLD;
    tYSequencer   = RC_HOLD;
    tZSequencer   = RC_HOLD;
    case (state)
      S_EXEC: begin
        case (comandSequencer)
          OP_LDX: tXSequencer = RC_LOAD;
          OP_ADD: begin
            tULASequencer = ULA_ADD;
            tYSequencer   = RC_LOAD;
          end
          OP_SUB: begin
            tULASequencer = ULA_SUB;
            tYSequencer   = RC_LOAD;
          end
          OP_MUL: tULASequencer = ULA_MUL;
          OP_DIV: tULASequencer = ULA_DIV;
          OP_STZ: tZSequencer = RC_LOAD;
          OP_CLR: begin
            tXSequencer = RC_CLEAR;
            tYSequencer = RC_CLEAR;
            tZSequencer = RC_CLEAR;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        tULASequencer = ula_op;
        if (statusSequencer)
          tYSequencer = RC_LOAD;
      end
      default: ;
    endcase
  end

  assign addressSequencer = pc;
  assign busySequencer    = (state == S_FETCH) || (state == S_EXEC) || (state == S_WAIT);
  assign doneSequencer    = (state == S_HALT);
  assign errorSequencer   = (state == S_ERROR);

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer with a clocked program memory
module tb_program_sequencer;

  localparam logic [2:0] H = 3'd0;
  localparam logic [2:0] L = 3'd1;
  localparam logic [2:0] C = 3'd2;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        status;
    logic        chk;
    logic [19:0] exp;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       status = 1'b0;
  logic [7:0] mem [16];
  logic [7:0] mem_q = 8'h00;

  logic [3:0] addr, ula;
  logic [2:0] tx, ty, tz;
  logic       busy, done, err;

  ent_t q[$];
  int   passed = 0;
  int   total  = 0;

  program_sequencer dut (
    .clockSequencer  (clk),
    .resetSequencer  (rst),
    .startSequencer  (start),
    .comandSequencer (mem_q[7:4]),
    .jumpSequencer   (mem_q[3:0]),
    .statusSequencer (status),
    .addressSequencer(addr),
    .tULASequencer   (ula),
    .tXSequencer     (tx),
    .tYSequencer     (ty),
    .tZSequencer     (tz),
    .busySequencer   (busy),
    .doneSequencer   (done),
    .errorSequencer  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_q <= mem[addr];

  function automatic ent_t mk(input logic r, input logic s, input logic st, input logic c,
                              input logic [3:0] a, input logic [3:0] u,
                              input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                              input logic b, input logic d, input logic er);
    ent_t t;
    t.rst = r; t.start = s; t.status = st; t.chk = c;
    t.exp = {a, u, x, y, z, b, d, er};
    return t;
  endfunction

  function automatic ent_t e_rst();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, H, H, H, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic ent_t e_idle(input logic s, input logic st);
    return mk(1'b0, s, st, 1'b1, 4'd0, 4'd0, H, H, H, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic ent_t e_busy(input logic [3:0] a, input logic [3:0] u,
                                  input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                                  input logic st);
    return mk(1'b0, 1'b0, st, 1'b1, a, u, x, y, z, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] obs();
    return {addr, ula, tx, ty, tz, busy, done, err};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    q.push_back(e_rst());
    q.push_back(e_idle(1'b0, 1'b0));
    q.push_back(e_idle(1'b0, 1'b1));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL reset cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_program();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h60; mem[3] = 8'hF0;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, L, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, L, H, 1'b0));
    q.push_back(e_busy(4'd2, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd2, 4'd0, H, H, L, 1'b0));
    q.push_back(e_busy(4'd3, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd3, 4'd0, H, H, H, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 4'd0, H, H, H, 1'b0, 1'b1, 1'b0));
    q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd0, H, H, H, 1'b0, 1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, L, H, H, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL program cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_decode();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'h70; mem[2] = 8'h50; mem[3] = 8'hF0;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd1, H, L, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, C, C, C, 1'b0));
    q.push_back(e_busy(4'd2, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd2, 4'd3, H, H, H, 1'b0));
    q.push_back(e_busy(4'd2, 4'd3, H, L, H, 1'b1));
    q.push_back(e_busy(4'd3, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd3, 4'd0, H, H, H, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, H, H, H, 1'b0, 1'b1, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL decode cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_mul_wait();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'hF0;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, H, H, 1'b0));
    // start mid-WAIT must not restart the program
    q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, H, H, H, 1'b1, 1'b0, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, L, H, 1'b1));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, H, H, H, 1'b0, 1'b1, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL mul_wait cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_wait_timeout();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'h57;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd3, H, H, H, 1'b0));
    for (int i = 0; i < 16; i++) q.push_back(e_busy(4'd1, 4'd3, H, H, H, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, H, H, H, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, H, H, H, 1'b0, 1'b0, 1'b1));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL wait_timeout cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_jump();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[5] = 8'h82;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    for (int i = 0; i < 6; i++) begin
      q.push_back(e_busy(4'(i), 4'd0, H, H, H, 1'b0));
      q.push_back(e_busy(4'(i), 4'd0, H, H, H, 1'b0));
    end
    q.push_back(e_busy(4'd2, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd2, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd3, 4'd0, H, H, H, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL jump cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_wrap();
    ent_t cur; int cyc = 0; logic [19:0] got;
    for (int i = 0; i < 16; i++) mem[i] = {4'h0, 4'(15 - i)};
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    for (int i = 0; i < 17; i++) begin
      q.push_back(e_busy(4'(i % 16), 4'd0, H, H, H, 1'b0));
      q.push_back(e_busy(4'(i % 16), 4'd0, H, H, H, 1'b0));
    end
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL wrap cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[1] = 8'hC3;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd1, 4'd0, H, H, H, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, H, H, H, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, H, H, H, 1'b0, 1'b0, 1'b1));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL illegal cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  task automatic test_reset_in_wait();
    ent_t cur; int cyc = 0; logic [19:0] got;
    clear_mem();
    mem[0] = 8'h40;
    q.push_back(e_rst());
    q.push_back(e_idle(1'b1, 1'b0));
    q.push_back(e_busy(4'd0, 4'd0, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, H, H, 1'b0));
    q.push_back(e_busy(4'd0, 4'd2, H, H, H, 1'b0));
    q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, H, L, H, 1'b1, 1'b0, 1'b0));
    q.push_back(e_idle(1'b0, 1'b1));
    q.push_back(e_idle(1'b0, 1'b0));
    while (q.size() > 0) begin
      cur = q.pop_front();
      @(posedge clk); #1;
      rst = cur.rst; start = cur.start; status = cur.status;
      #2;
      if (cur.chk) begin
        got = obs(); total++;
        if (got !== cur.exp) $display("FAIL reset_in_wait cycle %0d: got %h expected %h", cyc, got, cur.exp);
        else passed++;
      end
      cyc++;
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_program();
    test_decode();
    test_mul_wait();
    test_wait_timeout();
    test_jump();
    test_wrap();
    test_illegal();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
